// File: rtl/mouse_tracker.sv
// -----------------------------------------------------------------------------
// mouse_tracker
//
// Converts raw pointer hardware (quadrature X encoder plus a bouncy active-low
// button, all asynchronous to clock) into a clean mouse-state bus: a clamped
// position counter and a debounced active-low button.
//
// Ports:
//   clock           in   system clock, rising edge
//   reset_          in   asynchronous active-low reset
//   quad_a, quad_b  in   encoder phases, asynchronous
//   button_         in   raw button, active-low, bouncy, asynchronous
//   home            in   synchronous; loads position 0 (wins over any step)
//   mouse_x         out  current position, 0..X_MAX
//   mouse_pressed_  out  debounced button, active-low
//   moved           out  one-cycle pulse when a step changes mouse_x
//   quad_error      out  one-cycle pulse on an illegal quadrature transition
// -----------------------------------------------------------------------------
module mouse_tracker #(
    parameter int WIDTH           = 16,
    parameter int X_MAX           = 639,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             button_,
    input  logic             home,
    output logic [WIDTH-1:0] mouse_x,
    output logic             mouse_pressed_,
    output logic             moved,
    output logic             quad_error
);

    // A one-cycle debounce still needs a 1-bit counter.
    localparam int               DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] X_LIMIT = WIDTH'(X_MAX);

    // -------------------------------------------------------------------------
    // Two-flop synchronizers. Quad phases idle at 0, the button idles released.
    // -------------------------------------------------------------------------
    logic [1:0] quad_meta;
    logic [1:0] s;
    logic       button_meta;
    logic       bs;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its source; blocking here would collapse the two
    // synchronizer stages into one.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            quad_meta   <= 2'b00;
            s           <= 2'b00;
            button_meta <= 1'b1;
            bs          <= 1'b1;
        end else begin
            quad_meta   <= {quad_a, quad_b};
            s           <= quad_meta;
            button_meta <= button_;
            bs          <= button_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Priming: the first three edges after reset would see reset values
    // flowing out of the synchronizers as fake transitions, so decode is
    // held off until prime_cnt saturates.
    // -------------------------------------------------------------------------
    logic [1:0] prime_cnt;
    logic       primed;
    logic [1:0] prev;

    assign primed = (prime_cnt == 2'd3);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            prime_cnt <= 2'd0;
            prev      <= 2'b00;
        end else begin
            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
            prev <= s;
        end
    end

    // -------------------------------------------------------------------------
    // Quadrature decode: Gray-code walk 00->01->11->10->00 is forward.
    // -------------------------------------------------------------------------
    logic step_inc;
    logic step_dec;
    logic step_err;

    // NOTE: every always_comb output is given a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        step_inc = 1'b0;
        step_dec = 1'b0;
        step_err = 1'b0;
        unique case ({prev, s})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_inc = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_dec = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_err = 1'b1;
            default: ;  // no change
        endcase
    end

    // -------------------------------------------------------------------------
    // Position counter. Limits are checked before the add/subtract so the
    // counter never wraps and a clamped step never raises moved.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            mouse_x    <= '0;
            moved      <= 1'b0;
            quad_error <= 1'b0;
        end else begin
            moved      <= 1'b0;
            quad_error <= primed && step_err;
            if (home) begin
                mouse_x <= '0;
            end else if (primed && step_inc && (mouse_x != X_LIMIT)) begin
                mouse_x <= mouse_x + 1'b1;
                moved   <= 1'b1;
            end else if (primed && step_dec && (mouse_x != '0)) begin
                mouse_x <= mouse_x - 1'b1;
                moved   <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: the synchronized button must disagree with the output for
    // DEBOUNCE_CYCLES consecutive edges before the output follows it; any
    // agreement in between restarts the count.
    // -------------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            db_cnt         <= '0;
            mouse_pressed_ <= 1'b1;
        end else if (bs == mouse_pressed_) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            mouse_pressed_ <= bs;
            db_cnt         <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mouse_tracker.sv
// -----------------------------------------------------------------------------
// tb_mouse_tracker
//
// Self-checking bench for mouse_tracker with default parameters. Quadrature
// stimulus is table driven: each record is one encoder state held for four
// clocks with the expected position and pulses; home may be asserted on the
// edge the step decodes. Debounce, priming and asynchronous reset are covered
// by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mouse_tracker;

    localparam int X_MAX = 639;

    logic        clock;
    logic        reset_;
    logic        quad_a;
    logic        quad_b;
    logic        button_;
    logic        home;
    logic [15:0] mouse_x;
    logic        mouse_pressed_;
    logic        moved;
    logic        quad_error;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       a;
        logic       b;
        logic       home;
        int         exp_x;
        logic       exp_moved;
        logic       exp_err;
    } vec_t;

    vec_t pre_vecs[$];
    vec_t post_vecs[$];

    mouse_tracker #(
        .WIDTH          (16),
        .X_MAX          (X_MAX),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock          (clock),
        .reset_         (reset_),
        .quad_a         (quad_a),
        .quad_b         (quad_b),
        .button_        (button_),
        .home           (home),
        .mouse_x        (mouse_x),
        .mouse_pressed_ (mouse_pressed_),
        .moved          (moved),
        .quad_error     (quad_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic a, input logic b, input logic h,
                                input int x, input logic m, input logic e);
        vec_t v;
        v.a = a; v.b = b; v.home = h;
        v.exp_x = x; v.exp_moved = m; v.exp_err = e;
        return v;
    endfunction

    function automatic logic [1:0] fwd_next(input logic [1:0] st);
        case (st)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Drive one encoder state: E0 captures it, E1 moves it into s, E2 shows
    // the decode result, E3 must show the pulses gone again.
    task automatic apply(input vec_t v, input string tag);
        quad_a = v.a;
        quad_b = v.b;
        tick();                                    // E0
        tick();                                    // E1
        check({tag, "_early_moved"}, 32'(moved), 32'(1'b0));
        if (v.home) home = 1'b1;
        tick();                                    // E2
        home = 1'b0;
        check({tag, "_x"},     32'(mouse_x),    32'(v.exp_x));
        check({tag, "_moved"}, 32'(moved),      32'(v.exp_moved));
        check({tag, "_err"},   32'(quad_error), 32'(v.exp_err));
        tick();                                    // E3
        check({tag, "_moved_off"}, 32'(moved),      32'(1'b0));
        check({tag, "_err_off"},   32'(quad_error), 32'(1'b0));
    endtask

    initial begin
        logic [1:0] cur;
        int         exp_x;

        // ---- stimulus tables -------------------------------------------------
        // Starting from s=11, x=0 (after priming).
        pre_vecs.push_back(mk(0, 1, 0, 0, 0, 0));   // 11->01 reverse, clamped at 0
        pre_vecs.push_back(mk(0, 0, 0, 0, 0, 0));   // 01->00 reverse, clamped at 0
        pre_vecs.push_back(mk(0, 1, 0, 1, 1, 0));   // forward
        pre_vecs.push_back(mk(1, 1, 0, 2, 1, 0));
        pre_vecs.push_back(mk(1, 0, 0, 3, 1, 0));
        pre_vecs.push_back(mk(0, 0, 0, 4, 1, 0));
        pre_vecs.push_back(mk(1, 0, 0, 3, 1, 0));   // reverse x3
        pre_vecs.push_back(mk(1, 1, 0, 2, 1, 0));
        pre_vecs.push_back(mk(0, 1, 0, 1, 1, 0));
        // Ramp from s=01,x=1 by 638 forward steps ends at s=10, x=639.
        post_vecs.push_back(mk(0, 0, 0, X_MAX, 0, 0)); // clamped at X_MAX
        post_vecs.push_back(mk(0, 1, 0, X_MAX, 0, 0));
        post_vecs.push_back(mk(1, 1, 0, X_MAX, 0, 0));
        post_vecs.push_back(mk(1, 0, 0, X_MAX, 0, 0));
        post_vecs.push_back(mk(0, 0, 0, X_MAX, 0, 0));
        post_vecs.push_back(mk(0, 0, 1, 0, 0, 0));     // home, no step
        post_vecs.push_back(mk(1, 0, 0, 0, 0, 0));     // reverse, clamped at 0
        post_vecs.push_back(mk(1, 1, 0, 0, 0, 0));
        post_vecs.push_back(mk(0, 0, 0, 0, 0, 1));     // 11->00 illegal jump
        post_vecs.push_back(mk(0, 1, 0, 1, 1, 0));     // forward up to 10
        post_vecs.push_back(mk(1, 1, 0, 2, 1, 0));
        post_vecs.push_back(mk(1, 0, 0, 3, 1, 0));
        post_vecs.push_back(mk(0, 0, 0, 4, 1, 0));
        post_vecs.push_back(mk(0, 1, 0, 5, 1, 0));
        post_vecs.push_back(mk(1, 1, 0, 6, 1, 0));
        post_vecs.push_back(mk(1, 0, 0, 7, 1, 0));
        post_vecs.push_back(mk(0, 0, 0, 8, 1, 0));
        post_vecs.push_back(mk(0, 1, 0, 9, 1, 0));
        post_vecs.push_back(mk(1, 1, 0, 10, 1, 0));
        post_vecs.push_back(mk(1, 0, 1, 0, 0, 0));     // forward step + home same edge
        post_vecs.push_back(mk(0, 1, 1, 0, 0, 1));     // illegal jump + home: error kept
        post_vecs.push_back(mk(1, 0, 0, 0, 0, 1));     // 01->10 illegal jump
        post_vecs.push_back(mk(0, 0, 0, 1, 1, 0));     // 10->00 forward

        // ---- reset with both phases high, then priming ----------------------
        reset_  = 1'b0;
        quad_a  = 1'b1;
        quad_b  = 1'b1;
        button_ = 1'b1;
        home    = 1'b0;
        #12;
        check("rst_x",       32'(mouse_x),        32'd0);
        check("rst_pressed", 32'(mouse_pressed_), 32'd1);
        check("rst_moved",   32'(moved),          32'd0);
        check("rst_err",     32'(quad_error),     32'd0);
        #11 reset_ = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("prime%0d_moved", i), 32'(moved),      32'd0);
            check($sformatf("prime%0d_err", i),   32'(quad_error), 32'd0);
        end
        check("prime_x", 32'(mouse_x), 32'd0);

        // ---- table part 1 ---------------------------------------------------
        foreach (pre_vecs[i]) apply(pre_vecs[i], $sformatf("pre%0d", i));

        // ---- ramp to X_MAX --------------------------------------------------
        cur   = 2'b01;
        exp_x = 1;
        for (int k = 0; k < X_MAX - 1; k++) begin
            cur = fwd_next(cur);
            exp_x++;
            apply(mk(cur[1], cur[0], 0, exp_x, 1, 0), $sformatf("ramp%0d", k));
        end

        // ---- table part 2 ---------------------------------------------------
        foreach (post_vecs[i]) apply(post_vecs[i], $sformatf("post%0d", i));

        // ---- debounce: glitchy press ----------------------------------------
        for (int i = 0; i < 20; i++) begin
            button_ = (i % 3 == 2) ? 1'b1 : 1'b0;
            tick();
            check($sformatf("glitch%0d_pressed", i), 32'(mouse_pressed_), 32'd1);
        end
        // Last glitch was i=17; low since i=18 (E0), loop ended after E1.
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("press_E%0d", i), 32'(mouse_pressed_), 32'd1);
        end
        tick();
        check("press_E5", 32'(mouse_pressed_), 32'd0);

        // ---- debounce: clean release ----------------------------------------
        button_ = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            tick();
            check($sformatf("release_E%0d", i), 32'(mouse_pressed_), 32'd0);
        end
        tick();
        check("release_E5", 32'(mouse_pressed_), 32'd1);

        // ---- async reset mid-debounce (counter=2) ---------------------------
        button_ = 1'b0;
        for (int i = 0; i < 4; i++) tick();        // E0..E3: counter at 2
        check("middb_pressed_pre", 32'(mouse_pressed_), 32'd1);
        #2 reset_ = 1'b0;
        #1;
        check("middb_rst_x",       32'(mouse_x),        32'd0);
        check("middb_rst_pressed", 32'(mouse_pressed_), 32'd1);
        button_ = 1'b1;
        quad_a  = 1'b0;
        quad_b  = 1'b0;
        tick();
        reset_ = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("middb_after%0d_pressed", i), 32'(mouse_pressed_), 32'd1);
        end

        // ---- ramp to 300, then async reset with moved high -------------------
        cur   = 2'b00;
        exp_x = 0;
        for (int k = 0; k < 300; k++) begin
            cur = fwd_next(cur);
            exp_x++;
            quad_a = cur[1];
            quad_b = cur[0];
            repeat (4) tick();
        end
        check("ramp300_x", 32'(mouse_x), 32'(exp_x));
        cur    = fwd_next(cur);
        quad_a = cur[1];
        quad_b = cur[0];
        repeat (3) tick();
        check("ramp301_x",     32'(mouse_x), 32'd301);
        check("ramp301_moved", 32'(moved),   32'd1);
        #2 reset_ = 1'b0;
        #1;
        check("midramp_rst_x",       32'(mouse_x),        32'd0);
        check("midramp_rst_moved",   32'(moved),          32'd0);
        check("midramp_rst_err",     32'(quad_error),     32'd0);
        check("midramp_rst_pressed", 32'(mouse_pressed_), 32'd1);

        // Inputs held at 01: without priming, 00->01 would decode as a step.
        tick();
        reset_ = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("reprime%0d_moved", i), 32'(moved),   32'd0);
            check($sformatf("reprime%0d_x", i),     32'(mouse_x), 32'd0);
        end
        apply(mk(1, 1, 0, 1, 1, 0), "first_step");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
